merge_pulse_counter: RTL and testbench
======================================

# merge_pulse_counter

Clocked accumulator that sits directly downstream of an RSFQ merge cell. It consumes the merge's toggle-encoded output, where every edge of the line is one SFQ pulse. It counts pulses per readout window and emits a toggle-encoded carry line plus a snapshot word. It is the bridge between asynchronous pulse-level cell models and clocked test or readout logic in mixed-signal benches.

## Interface
- WIDTH, 4: accumulator and snapshot width in bits; legal range 2..16.
- SYNC_STAGES, 2: synchroniser flops on `a` and `rd`; legal range 0..3; 0 means the inputs are already synchronous to `clk`.
- HOLDOFF, 8: clock cycles after reset release during which input edges are ignored; legal range 1..255.
- clk, input, 1: single clock, rising-edge active.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- a, input, 1: toggle-encoded pulse line from the merge output; each edge (rise or fall) is one pulse.
- rd, input, 1: toggle-encoded readout request; each edge is one request.
- q, output, 1: toggle-encoded carry line; toggles once per accumulator wrap.
- count, output, WIDTH: snapshot of the accumulator taken at the last readout.
- cnt_valid, output, 1: one-cycle strobe in the cycle `count` is updated.
- ovf, output, 1: set if the accumulator wrapped at least once in the window that `count` describes.

## Operation
- Front end:
  - `a` and `rd` each pass through SYNC_STAGES flops.
  - A history flop per line gives the pulse condition `pa = a_s ^ a_h` and the request condition `pr = rd_s ^ rd_h`.
  - History flops update every cycle in every state, so a line level that exists at reset release is never counted.
- State machine:
  - INIT: entered on reset. A holdoff counter is loaded with HOLDOFF and decrements each cycle. `pa` and `pr` are ignored. When the counter reaches 0, the next cycle is RUN.
  - RUN: normal counting. The block stays in RUN until reset.
- Counting in RUN when `pa=1` and `pr=0`:
  - acc <= acc+1, modulo 2^WIDTH.
  - On the wrap from 2^WIDTH-1 to 0, q <= ~q and win_ovf <= 1.
- Readout in RUN when `pr=1`:
  - count <= acc, ovf <= win_ovf, cnt_valid <= 1.
  - acc <= pa, so a pulse in the same cycle opens the new window and is excluded from the snapshot.
  - win_ovf <= 0.
  - No wrap and no q toggle occur in a readout cycle.
- cnt_valid is 0 in every cycle that has no readout.
- Reset values: q=0, count=0, cnt_valid=0, ovf=0. Internal acc=0, win_ovf=0, all history and sync flops 0, state INIT.
- Reset asserted mid-operation clears everything immediately and asynchronously. Counting resumes only after a full HOLDOFF period.

## Timing
- An edge on `a` that meets setup at edge k reaches acc at edge k+SYNC_STAGES+1.
- The q toggle is registered in the same edge as the wrapping acc update.
- An edge on `rd` that meets setup at edge k updates count, ovf and cnt_valid at edge k+SYNC_STAGES+1. cnt_valid is high for exactly one cycle.
- Minimum input spacing is one clock period per line. Two edges on one line between consecutive sampling edges cancel and count as zero pulses. This is the clocked equivalent of the merge cell's self-hold constraint and is the source's responsibility.
- Simultaneous edges on `a` and `rd` in one cycle: the pulse counts into the new window (acc=1), and the snapshot holds the old value.
- Back-to-back `rd` edges on consecutive cycles: two strobes; the second snapshot is 0, or 1 if a pulse arrived in between.
- First countable edge: any edge sampled at or after the first RUN cycle.

## Test plan
- Reset, then no input activity for HOLDOFF+5 cycles -> q=0, count=0, cnt_valid=0, ovf=0 throughout; a single `rd` edge then yields count=0, ovf=0 and one strobe.
- Defaults (WIDTH=4, SYNC_STAGES=2). After HOLDOFF, 5 `a` edges spaced 2 cycles apart, then one `rd` edge -> cnt_valid high for 1 cycle exactly 3 edges after the rd edge, count=5, ovf=0, q unchanged.
- 17 `a` edges, then `rd` -> q toggles once, on the 16th pulse's acc update; count=1, ovf=1. A second `rd` with no pulses -> count=0, ovf=0.
- `a` and `rd` edges in the same cycle with acc=3 -> count=3; a following `rd` with no further pulses -> count=1.
- `a` held high before and during reset release, plus 3 `a` edges during INIT -> none counted; after HOLDOFF, `rd` gives count=0.
- Reset asserted mid-window with acc=9 and q=1 -> all outputs are 0 immediately, without waiting for a clock edge. After HOLDOFF, 2 pulses then `rd` -> count=2, ovf=0.

Source files
------------

// File: rtl/merge_pulse_counter.sv
// Pulse accumulator for toggle-encoded RSFQ merge output.
// Counts edges per readout window; emits toggle carry and snapshot.
module merge_pulse_counter #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             rd,
  output logic             q,
  output logic [WIDTH-1:0] count,
  output logic             cnt_valid,
  output logic             ovf
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

  logic             a_s;
  logic             rd_s;
  logic             a_h;
  logic             rd_h;
  logic             pa;
  logic             pr;
  logic [0:0]       state;
  logic [7:0]       hold;
  logic [WIDTH-1:0] acc;
  logic             win_ovf;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign a_s  = a;
      assign rd_s = rd;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] a_sh;
      logic [SYNC_STAGES-1:0] rd_sh;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sh  <= '0;
          rd_sh <= '0;
        end else begin
          a_sh[0]  <= a;
          rd_sh[0] <= rd;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            a_sh[i]  <= a_sh[i-1];
            rd_sh[i] <= rd_sh[i-1];
          end
        end
      end

      assign a_s  = a_sh[SYNC_STAGES-1];
      assign rd_s = rd_sh[SYNC_STAGES-1];
    end
  endgenerate

  // Edge detect runs in every state so a level at release never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_h  <= 1'b0;
      rd_h <= 1'b0;
      pa   <= 1'b0;
      pr   <= 1'b0;
    end else begin
      a_h  <= a_s;
      rd_h <= rd_s;
      pa   <= a_s ^ a_h;
      pr   <= rd_s ^ rd_h;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      hold      <= HOLD_INIT;
      acc       <= '0;
      win_ovf   <= 1'b0;
      q         <= 1'b0;
      count     <= '0;
      cnt_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      case (state)
        INIT: begin
          if (hold <= 8'd1) begin
            hold  <= 8'd0;
            state <= RUN;
          end else begin
            hold <= hold - 8'd1;
          end
        end
        RUN: begin
          if (pr) begin
            count     <= acc;
            ovf       <= win_ovf;
            cnt_valid <= 1'b1;
            acc       <= WIDTH'(pa);
            win_ovf   <= 1'b0;
          end else if (pa) begin
            acc <= acc + WIDTH'(1);
            if (&acc) begin
              q       <= ~q;
              win_ovf <= 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_pulse_counter.sv
// Directed scoreboard bench for merge_pulse_counter.
// Snapshots are queued at each rd edge and checked on cnt_valid.
module tb_merge_pulse_counter;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       rd;
  logic       q;
  logic [3:0] count;
  logic       cnt_valid;
  logic       ovf;

  int passed;
  int failed;
  int total;
  int cyc;
  int nstrobe;
  int last_strobe;

  logic [3:0] m_acc;
  logic       m_wovf;
  logic       m_q;
  logic [4:0] sb[$];

  merge_pulse_counter #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .HOLDOFF(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .rd(rd),
    .q(q),
    .count(count),
    .cnt_valid(cnt_valid),
    .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (cnt_valid === 1'b1) begin
      nstrobe++;
      last_strobe = cyc;
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e[4:1]));
        chk("ovf", 32'(ovf), 32'(e[0]));
      end
    end
  endtask

  task automatic model_pulse();
    if (m_acc == 4'hf) begin
      m_q    = ~m_q;
      m_wovf = 1'b1;
    end
    m_acc = m_acc + 4'd1;
  endtask

  task automatic model_clear();
    m_acc  = '0;
    m_wovf = 1'b0;
    m_q    = 1'b0;
    sb.delete();
  endtask

  task automatic pulse(input int gap);
    a = ~a;
    model_pulse();
    repeat (gap) tick();
  endtask

  task automatic do_rd(input bit with_pulse);
    int s0;
    int start;
    bit seen;
    rd = ~rd;
    sb.push_back({m_acc, m_wovf});
    m_acc  = '0;
    m_wovf = 1'b0;
    if (with_pulse) begin
      a = ~a;
      model_pulse();
    end
    s0    = nstrobe;
    start = cyc;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (nstrobe != s0) seen = 1'b1;
    end
    chk("rd_seen", 32'(seen), 1);
    if (seen) chk("rd_lat", last_strobe - start, 4);
    tick();
    chk("strobe_width", 32'(cnt_valid), 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    passed = 0; failed = 0; total = 0;
    cyc = 0; nstrobe = 0; last_strobe = 0;
    rst_n = 1'b0;
    a = 1'b0;
    rd = 1'b0;
    model_clear();
    #12;
    chk("rst_outs", {q, count, cnt_valid, ovf}, 0);
    release_rst();

    repeat (13) begin
      tick();
      chk("idle", {q, count, cnt_valid, ovf}, 0);
    end
    do_rd(0);

    repeat (5) pulse(2);
    repeat (4) tick();
    chk("q_keep", 32'(q), 32'(m_q));
    do_rd(0);

    repeat (15) pulse(2);
    repeat (4) tick();
    chk("q_pre_wrap", 32'(q), 32'(m_q));
    pulse(3);
    chk("q_not_yet", 32'(q), 0);
    tick();
    chk("q_wrap", 32'(q), 32'(m_q));
    pulse(2);
    do_rd(0);
    do_rd(0);

    repeat (3) pulse(2);
    do_rd(1);
    do_rd(0);

    pulse(2);
    s0 = nstrobe;
    rd = ~rd;
    sb.push_back({m_acc, m_wovf});
    m_acc = '0;
    m_wovf = 1'b0;
    tick();
    rd = ~rd;
    sb.push_back({m_acc, m_wovf});
    repeat (8) tick();
    chk("b2b_strobes", nstrobe - s0, 2);

    a = 1'b1;
    rst_n = 1'b0;
    model_clear();
    #3;
    chk("rst2_outs", {q, count, cnt_valid, ovf}, 0);
    release_rst();
    tick();
    a = 1'b0;
    tick();
    a = 1'b1;
    tick();
    a = 1'b0;
    repeat (20) tick();
    do_rd(0);

    repeat (9) pulse(2);
    do_rd(0);
    repeat (25) pulse(2);
    repeat (4) tick();
    chk("q_mid", 32'(q), 32'(m_q));
    chk("count_mid", 32'(count), 9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_q", 32'(q), 0);
    chk("async_count", 32'(count), 0);
    chk("async_valid", 32'(cnt_valid), 0);
    chk("async_ovf", 32'(ovf), 0);
    model_clear();
    release_rst();
    repeat (13) tick();
    repeat (2) pulse(2);
    do_rd(0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
